// File: rtl/fib_req_arb.sv
// fib_req_arb
//   Shares one FIB lookup engine between NPORT packet parsers. Parser requests
//   are round-robin arbitrated onto a single registered request channel and
//   tagged with the source port. FIB results are steered back to the port named
//   in the result tag. A port holds at most one lookup in flight. It is not
//   granted again until its result has been loaded into its f2p register.
//
//   Handshake (every interface): a beat transfers in a cycle where srdy and drdy
//   are both high. A source that raises srdy keeps srdy and data stable until
//   that transfer happens. drdy may change freely.
//
// Ports
//   clk                 rising-edge clock
//   reset               asynchronous, active-low reset
//   p2f_srdy/drdy/data  per-port parse requests (port i at [i*REQ_SZ +: REQ_SZ])
//   req_srdy/drdy       registered request channel to the FIB
//   req_port/req_data   source port tag and payload of the pending request
//   res_srdy/drdy       result channel from the FIB
//   res_port/res_data   destination port tag and payload of the result
//   f2p_srdy/drdy/data  per-port registered results (same slicing as p2f_data)
//   res_drop            one-cycle pulse after a result is accepted but discarded
module fib_req_arb #(
  parameter int NPORT   = 4,
  parameter int PORT_SZ = 2,
  parameter int REQ_SZ  = 96,
  parameter int RES_SZ  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NPORT-1:0]        p2f_srdy,
  output logic [NPORT-1:0]        p2f_drdy,
  input  logic [NPORT*REQ_SZ-1:0] p2f_data,
  output logic                    req_srdy,
  input  logic                    req_drdy,
  output logic [PORT_SZ-1:0]      req_port,
  output logic [REQ_SZ-1:0]       req_data,
  input  logic                    res_srdy,
  output logic                    res_drdy,
  input  logic [PORT_SZ-1:0]      res_port,
  input  logic [RES_SZ-1:0]       res_data,
  output logic [NPORT-1:0]        f2p_srdy,
  input  logic [NPORT-1:0]        f2p_drdy,
  output logic [NPORT*RES_SZ-1:0] f2p_data,
  output logic                    res_drop
);

  logic                    r_req_srdy;
  logic [PORT_SZ-1:0]      r_req_port;
  logic [REQ_SZ-1:0]       r_req_data;
  logic [PORT_SZ-1:0]      r_rr_ptr;
  logic [NPORT-1:0]        r_outstanding;
  logic [NPORT-1:0]        r_f2p_srdy;
  logic [NPORT*RES_SZ-1:0] r_f2p_data;
  logic                    r_res_drop;

  logic                    w_free;
  logic [NPORT-1:0]        w_elig;
  logic                    w_found;
  logic                    w_grant_vld;
  logic [NPORT-1:0]        w_grant_oh;
  logic [PORT_SZ-1:0]      w_grant_idx;
  logic [REQ_SZ-1:0]       w_grant_data;
  logic [PORT_SZ-1:0]      w_ptr_nxt;
  logic [NPORT-1:0]        w_res_load;
  logic                    w_res_xfer;
  logic                    w_res_drop;

  // (base + k) mod NPORT for base, k < NPORT.
  function automatic int rr_idx(input int base, input int k);
    int s;
    s = base + k;
    if (s >= NPORT) s = s - NPORT;
    return s;
  endfunction

  // The output register can take a new request when empty or draining now.
  assign w_free = ~r_req_srdy | req_drdy;
  // A port with a lookup in flight is locked out, even if its result is
  // loading in this same cycle.
  assign w_elig = p2f_srdy & ~r_outstanding;

  // Round-robin search starting at r_rr_ptr. The first eligible port wins.
  always_comb begin
    w_found      = 1'b0;
    w_grant_oh   = '0;
    w_grant_idx  = '0;
    w_grant_data = '0;
    w_ptr_nxt    = r_rr_ptr;
    for (int k = 0; k < NPORT; k++) begin
      if (!w_found && w_elig[rr_idx(int'(r_rr_ptr), k)]) begin
        w_found      = 1'b1;
        w_grant_oh[rr_idx(int'(r_rr_ptr), k)] = 1'b1;
        w_grant_idx  = PORT_SZ'(rr_idx(int'(r_rr_ptr), k));
        w_grant_data = p2f_data[rr_idx(int'(r_rr_ptr), k)*REQ_SZ +: REQ_SZ];
        w_ptr_nxt    = PORT_SZ'(rr_idx(rr_idx(int'(r_rr_ptr), k), 1));
      end
    end
  end

  // Parsers never see an accept while reset is held.
  assign w_grant_vld = w_found & w_free & reset;
  assign p2f_drdy    = w_grant_vld ? w_grant_oh : '0;

  // Result steering. A tag beyond NPORT is always accepted (and dropped).
  // A result for a port with nothing outstanding is also dropped.
  always_comb begin
    res_drdy   = 1'b1;
    w_res_load = '0;
    for (int p = 0; p < NPORT; p++) begin
      if (int'(res_port) == p) begin
        res_drdy      = ~r_f2p_srdy[p] | f2p_drdy[p];
        w_res_load[p] = r_outstanding[p];
      end
    end
    w_res_xfer = res_srdy & res_drdy;
    w_res_load = w_res_load & {NPORT{w_res_xfer}};
    w_res_drop = w_res_xfer & ~(|w_res_load);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_req_srdy    <= 1'b0;
      r_req_port    <= '0;
      r_req_data    <= '0;
      r_rr_ptr      <= '0;
      r_outstanding <= '0;
      r_f2p_srdy    <= '0;
      r_f2p_data    <= '0;
      r_res_drop    <= 1'b0;
    end else begin
      if (w_free) begin
        r_req_srdy <= w_grant_vld;
        if (w_grant_vld) begin
          r_req_port <= w_grant_idx;
          r_req_data <= w_grant_data;
          r_rr_ptr   <= w_ptr_nxt;
        end
      end
      // A granted port never has a result loading in the same cycle
      // (it was ineligible), so set and clear never collide.
      r_outstanding <= (r_outstanding & ~w_res_load) |
                       (w_grant_vld ? w_grant_oh : '0);
      for (int p = 0; p < NPORT; p++) begin
        if (w_res_load[p]) begin
          r_f2p_srdy[p]                   <= 1'b1;
          r_f2p_data[p*RES_SZ +: RES_SZ] <= res_data;
        end else if (f2p_drdy[p]) begin
          r_f2p_srdy[p] <= 1'b0;
        end
      end
      r_res_drop <= w_res_drop;
    end
  end

  assign req_srdy = r_req_srdy;
  assign req_port = r_req_port;
  assign req_data = r_req_data;
  assign f2p_srdy = r_f2p_srdy;
  assign f2p_data = r_f2p_data;
  assign res_drop = r_res_drop;

endmodule
